// File: rtl/mc_control_if.sv
// ============================================================================
//  Module      : mc_control_if
//  Description : Instruction/flag inputs and datapath control outputs of the
//                multicycle controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       reg_write;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pc_en;
  logic [2:0] alu_ctl;
  logic       illegal;
  logic       mem_err;
  logic [3:0] state;

  // Controller side
  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_read, mem_write, iord, ir_write, reg_write, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, pc_en, alu_ctl, illegal, mem_err, state
  );

  // Datapath / memory side
  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_read, mem_write, iord, ir_write, reg_write, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, pc_en, alu_ctl, illegal, mem_err, state
  );
endinterface

`default_nettype wire

// File: rtl/mc_control.sv
// ============================================================================
//  Module      : mc_control
//  Description : Multicycle MIPS-subset control FSM with memory-wait timeout.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_control #(
  parameter int unsigned TIMEOUT = 16
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  mc_control_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_cnt;
  logic       w_timeout;
  logic       w_hold;

  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_iord;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_memtoreg;
  logic       w_regdst;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_pcsrc;
  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic [2:0] w_alu_ctl;
  logic       w_illegal;
  logic       w_mem_err;

  assign w_timeout = (r_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      // Any exit from a wait (completion, abort or other state) restarts the count
      r_cnt   <= w_hold ? (r_cnt + 8'd1) : 8'd0;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_hold          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_iord          = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_write     = 1'b0;
    w_memtoreg      = 1'b0;
    w_regdst        = 1'b0;
    w_alusrca       = 1'b0;
    w_alusrcb       = 2'b00;
    w_pcsrc         = 2'b00;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_alu_ctl       = 3'b010;
    w_illegal       = 1'b0;
    w_mem_err       = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_alusrcb  = 2'b01;
        if (bus.mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_timeout) begin
          w_mem_err    = 1'b1;
          w_state_next = S_FETCH;
        end else begin
          w_hold = 1'b1;
        end
      end

      S_DECODE: begin
        w_alusrcb = 2'b11;
        case (bus.opcode)
          c_op_lw, c_op_sw: w_state_next = S_MEMADR;
          c_op_rtype:       w_state_next = S_EXEC;
          c_op_beq:         w_state_next = S_BRANCH;
          c_op_j:           w_state_next = S_JUMP;
          c_op_addi:        w_state_next = S_ADDI_EX;
          default: begin
            w_illegal    = 1'b1;
            w_state_next = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = 2'b10;
        w_state_next = (bus.opcode == c_op_lw) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD, S_MEMWR: begin
        w_mem_read  = (r_state == S_MEMRD);
        w_mem_write = (r_state == S_MEMWR);
        w_iord      = 1'b1;
        if (bus.mem_ready) begin
          w_state_next = (r_state == S_MEMRD) ? S_MEMWB : S_FETCH;
        end else if (w_timeout) begin
          w_mem_err    = 1'b1;
          w_state_next = S_FETCH;
        end else begin
          w_hold = 1'b1;
        end
      end

      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_memtoreg   = 1'b1;
        w_state_next = S_FETCH;
      end

      S_EXEC: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = 2'b00;
        w_state_next = S_RWB;
        case (bus.funct)
          6'b100000: w_alu_ctl = 3'b010;
          6'b100010: w_alu_ctl = 3'b110;
          6'b100100: w_alu_ctl = 3'b000;
          6'b100101: w_alu_ctl = 3'b001;
          6'b101010: w_alu_ctl = 3'b111;
          default: begin
            w_illegal    = 1'b1;
            w_state_next = S_FETCH;
          end
        endcase
      end

      S_RWB: begin
        w_reg_write  = 1'b1;
        w_regdst     = 1'b1;
        w_state_next = S_FETCH;
      end

      S_BRANCH: begin
        w_alusrca       = 1'b1;
        w_alusrcb       = 2'b00;
        w_alu_ctl       = 3'b110;
        w_pc_write_cond = 1'b1;
        w_pcsrc         = 2'b01;
        w_state_next    = S_FETCH;
      end

      S_JUMP: begin
        w_pc_write   = 1'b1;
        w_pcsrc      = 2'b10;
        w_state_next = S_FETCH;
      end

      S_ADDI_EX: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = 2'b10;
        w_state_next = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        w_reg_write  = 1'b1;
        w_state_next = S_FETCH;
      end

      default: begin
        // Unused encodings drive nothing, not even the default ALU add
        w_alu_ctl    = 3'b000;
        w_state_next = S_FETCH;
      end
    endcase
  end

  // Outputs are held off while reset is asserted so FETCH cannot strobe memory
  assign bus.mem_read  = rst_n & w_mem_read;
  assign bus.mem_write = rst_n & w_mem_write;
  assign bus.iord      = rst_n & w_iord;
  assign bus.ir_write  = rst_n & w_ir_write;
  assign bus.reg_write = rst_n & w_reg_write;
  assign bus.memtoreg  = rst_n & w_memtoreg;
  assign bus.regdst    = rst_n & w_regdst;
  assign bus.alusrca   = rst_n & w_alusrca;
  assign bus.alusrcb   = {2{rst_n}} & w_alusrcb;
  assign bus.pcsrc     = {2{rst_n}} & w_pcsrc;
  assign bus.pc_en     = rst_n & (w_pc_write | (w_pc_write_cond & bus.zero));
  assign bus.alu_ctl   = {3{rst_n}} & w_alu_ctl;
  assign bus.illegal   = rst_n & w_illegal;
  assign bus.mem_err   = rst_n & w_mem_err;
  assign bus.state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_control.sv
// ============================================================================
//  Module      : tb_mc_control
//  Description : Directed and random instruction streams against an
//                instruction-level expected-trace model of mc_control.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_control;
  localparam int c_to = 4;
  localparam logic [5:0] c_r = 6'b000000, c_lw = 6'b100011, c_sw = 6'b101011;
  localparam logic [5:0] c_beq = 6'b000100, c_j = 6'b000010, c_addi = 6'b001000;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_read, mem_write, iord, ir_write, reg_write, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pc_en;
    logic [2:0] alu_ctl;
    logic       illegal, mem_err;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mc_control_if bus ();

  mc_control #(.TIMEOUT(c_to)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic obs_t sample();
    obs_t o;
    o = {bus.state, bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.reg_write,
         bus.memtoreg, bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pc_en,
         bus.alu_ctl, bus.illegal, bus.mem_err};
    return o;
  endfunction

  function automatic obs_t base(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    o.alu_ctl = 3'b010;
    return o;
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // {legal, alu code} for an R-type funct field
  function automatic logic [3:0] alu_ref(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b1_010;
      6'b100010: return 4'b1_110;
      6'b100100: return 4'b1_000;
      6'b100101: return 4'b1_001;
      6'b101010: return 4'b1_111;
      default:   return 4'b0_010;
    endcase
  endfunction

  task automatic chk(input obs_t e, input string tag);
    obs_t got;
    got = sample();
    total++;
    assert (got === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, e);
    end
  endtask

  // One clock cycle: drive inputs, compare mid-cycle, advance past the edge
  task automatic step(input obs_t e, input logic mr, input logic z, input string tag);
    bus.mem_ready = mr;
    bus.zero      = z;
    @(negedge clk);
    chk(e, tag);
    @(posedge clk);
    #1;
  endtask

  // A memory-wait state: completes on cycle w, aborts after c_to idle cycles
  task automatic mem_phase(input obs_t body, input int w, input bit is_fetch, output bit done);
    obs_t e;
    done = 1'b0;
    for (int c = 0; c < c_to; c++) begin
      e = body;
      if (c == w) begin
        if (is_fetch) begin
          e.ir_write = 1'b1;
          e.pc_en    = 1'b1;
        end
        step(e, 1'b1, rb(), "wait_done");
        done = 1'b1;
        break;
      end
      if (c == c_to - 1) e.mem_err = 1'b1;
      step(e, 1'b0, rb(), "wait_idle");
    end
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int wf,
                       input int wm, input logic zb);
    obs_t       e;
    bit         ok;
    logic [3:0] ar;
    bus.opcode = op;
    bus.funct  = fn;
    e = base(4'd0);
    e.mem_read = 1'b1;
    e.alusrcb  = 2'b01;
    mem_phase(e, wf, 1'b1, ok);
    if (!ok) return;
    e = base(4'd1);
    e.alusrcb = 2'b11;
    if (!(op inside {c_r, c_lw, c_sw, c_beq, c_j, c_addi})) e.illegal = 1'b1;
    step(e, rb(), rb(), "decode");
    case (op)
      c_lw, c_sw: begin
        e = base(4'd2);
        e.alusrca = 1'b1;
        e.alusrcb = 2'b10;
        step(e, rb(), rb(), "memadr");
        e = base((op == c_lw) ? 4'd3 : 4'd5);
        e.mem_read  = (op == c_lw);
        e.mem_write = (op == c_sw);
        e.iord      = 1'b1;
        mem_phase(e, wm, 1'b0, ok);
        if (ok && op == c_lw) begin
          e = base(4'd4);
          e.reg_write = 1'b1;
          e.memtoreg  = 1'b1;
          step(e, rb(), rb(), "memwb");
        end
      end
      c_r: begin
        ar = alu_ref(fn);
        e = base(4'd6);
        e.alusrca = 1'b1;
        e.alu_ctl = ar[2:0];
        e.illegal = ~ar[3];
        step(e, rb(), rb(), "exec");
        if (ar[3]) begin
          e = base(4'd7);
          e.reg_write = 1'b1;
          e.regdst    = 1'b1;
          step(e, rb(), rb(), "rwb");
        end
      end
      c_beq: begin
        e = base(4'd8);
        e.alusrca = 1'b1;
        e.alu_ctl = 3'b110;
        e.pcsrc   = 2'b01;
        e.pc_en   = zb;
        step(e, rb(), zb, "branch");
      end
      c_j: begin
        e = base(4'd9);
        e.pc_en = 1'b1;
        e.pcsrc = 2'b10;
        step(e, rb(), rb(), "jump");
      end
      c_addi: begin
        e = base(4'd10);
        e.alusrca = 1'b1;
        e.alusrcb = 2'b10;
        step(e, rb(), rb(), "addi_ex");
        e = base(4'd11);
        e.reg_write = 1'b1;
        step(e, rb(), rb(), "addi_wb");
      end
      default: ;
    endcase
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, c_to + 1)) : 0;
  endfunction

  initial begin
    logic [5:0] functs [5];
    logic [5:0] op;
    logic [5:0] fn;
    obs_t       e;
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    rst_n         = 1'b0;
    bus.opcode    = c_r;
    bus.funct     = 6'b100000;
    bus.zero      = 1'b1;
    bus.mem_ready = 1'b0;
    #3;
    chk('0, "reset_idle");
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk('0, "reset_ready");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    instr(c_r, 6'b100000, 0, 0, 1'b0);
    instr(c_lw, 6'b000000, 0, 3, 1'b0);
    instr(c_beq, 6'b000000, 0, 0, 1'b1);
    instr(c_beq, 6'b000000, 0, 0, 1'b0);
    instr(6'b111111, 6'b100000, 0, 0, 1'b0);
    instr(c_r, 6'b000000, 0, 0, 1'b0);
    instr(c_r, 6'b100010, c_to, 0, 1'b0);
    instr(c_r, 6'b101010, c_to - 1, 0, 1'b0);
    instr(c_sw, 6'b000000, 1, c_to + 1, 1'b0);
    instr(c_lw, 6'b000000, 2, c_to - 1, 1'b0);
    instr(c_j, 6'b000000, 0, 0, 1'b0);
    instr(c_addi, 6'b000000, 0, 0, 1'b0);

    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 7))
        0: op = c_r;
        1: op = c_lw;
        2: op = c_sw;
        3: op = c_beq;
        4: op = c_j;
        5: op = c_addi;
        6: op = c_r;
        default: begin
          op = 6'($urandom);
          while (op inside {c_r, c_lw, c_sw, c_beq, c_j, c_addi}) op = 6'($urandom);
        end
      endcase
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : functs[$urandom_range(0, 4)];
      instr(op, fn, rand_wait(), rand_wait(), rb());
    end

    // Reset in the middle of a store that is about to complete
    bus.opcode = c_sw;
    bus.funct  = 6'b000000;
    e = base(4'd0);
    e.mem_read = 1'b1;
    e.alusrcb  = 2'b01;
    e.ir_write = 1'b1;
    e.pc_en    = 1'b1;
    step(e, 1'b1, 1'b0, "sw_fetch");
    e = base(4'd1);
    e.alusrcb = 2'b11;
    step(e, 1'b0, 1'b0, "sw_decode");
    e = base(4'd2);
    e.alusrca = 1'b1;
    e.alusrcb = 2'b10;
    step(e, 1'b0, 1'b0, "sw_memadr");
    e = base(4'd5);
    e.mem_write = 1'b1;
    e.iord      = 1'b1;
    step(e, 1'b0, 1'b0, "sw_memwr_wait");
    bus.mem_ready = 1'b1;
    #1;
    chk(e, "sw_memwr_ready");
    #1;
    rst_n = 1'b0;
    #1;
    chk('0, "async_reset");
    @(posedge clk);
    #1;
    chk('0, "reset_held");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e = base(4'd0);
    e.mem_read = 1'b1;
    e.alusrcb  = 2'b01;
    step(e, 1'b0, 1'b1, "post_reset_fetch");
    instr(c_r, 6'b100100, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum consecutive memory-wait cycles before abort; legal range 1..255.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 opcode  in  6  instruction bits [31:26] from the instruction register.
REQ-005 funct  in  6  instruction bits [5:0] from the instruction register.
REQ-006 zero  in  1  ALU zero flag, combinational, same cycle.
REQ-007 mem_ready  in  1  memory completes the current access this cycle.
REQ-008 mem_read, mem_write  out  1 each  memory strobes.
REQ-009 iord  out  1  address select: 0 = PC, 1 = ALUOut.
REQ-010 ir_write, reg_write, memtoreg, regdst  out  1 each  datapath enables and selects.
REQ-011 alusrca  out  1  ALU operand A select: 0 = PC, 1 = reg A.
REQ-012 alusrcb  out  2  ALU operand B select: 00 = reg B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-013 pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-014 pc_en  out  1  PC load = pc_write | (pc_write_cond & zero).
REQ-015 alu_ctl  out  3  ALU function: 000 and, 001 or, 010 add, 110 sub, 111 slt.
REQ-016 illegal, mem_err  out  1 each  single-cycle error pulses.
REQ-017 state  out  4  current state, for debug.

Function
REQ-018 Outputs SHALL be Moore-decoded from state. Exceptions: ir_write and pc_en depend on mem_ready or zero as stated. Unlisted outputs SHALL be 0; alu_ctl SHALL default to 010.
REQ-019 Opcodes: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 000010 j, 001000 addi.
REQ-020 FETCH(0): mem_read=1, alusrcb=01, add. When mem_ready=1: ir_write=1, pc_write=1, goto DECODE. Otherwise hold.
REQ-021 DECODE(1): alusrcb=11, add. Next state by opcode: lw/sw -> MEMADR, R -> EXEC, beq -> BRANCH, j -> JUMP, addi -> ADDI_EX. Any other opcode: illegal=1, goto FETCH.
REQ-022 MEMADR(2): alusrca=1, alusrcb=10, add. lw -> MEMRD; sw -> MEMWR.
REQ-023 MEMRD(3): mem_read=1, iord=1. Goto MEMWB on mem_ready. MEMWB(4): reg_write=1, memtoreg=1, regdst=0, then FETCH.
REQ-024 MEMWR(5): mem_write=1, iord=1. Goto FETCH on mem_ready.
REQ-025 EXEC(6): alusrca=1, alusrcb=00. alu_ctl from funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111. Legal funct: goto RWB. Other funct: illegal=1, goto FETCH, no writeback.
REQ-026 RWB(7): reg_write=1, regdst=1, memtoreg=0, then FETCH.
REQ-027 BRANCH(8): alusrca=1, alusrcb=00, alu_ctl=110, pc_write_cond=1, pcsrc=01, then FETCH.
REQ-028 JUMP(9): pc_write=1, pcsrc=10, then FETCH.
REQ-029 ADDI_EX(10): alusrca=1, alusrcb=10, add, then ADDI_WB. ADDI_WB(11): reg_write=1, regdst=0, memtoreg=0, then FETCH.
REQ-030 Encodings 12-15 are unreachable. If entered, the block SHALL go to FETCH next cycle with all outputs 0.
REQ-031 Wait counter (8 bit): clears on entry to FETCH, MEMRD or MEMWR; increments each cycle those states hold with mem_ready=0.
REQ-032 When the counter equals TIMEOUT-1 with mem_ready=0: mem_err=1 for one cycle, goto FETCH. No ir_write, pc_en or reg_write in that cycle.
REQ-033 mem_ready=1 in the timeout cycle SHALL win: normal completion, no mem_err.
REQ-034 mem_ready outside FETCH, MEMRD and MEMWR SHALL be ignored.

Reset
REQ-035 While rst_n=0: state=FETCH, counter=0, every output 0 (gated, including mem_read). First FETCH outputs appear in the first cycle after rst_n rises.
REQ-036 Reset asserted mid-instruction SHALL abort it immediately, with no completing write strobes.

Verification
REQ-037 add (opcode 0, funct 100000), mem_ready=1 on fetch -> states 0,1,6,7,0; alu_ctl=010 in EXEC; reg_write=1 and regdst=1 in RWB.
REQ-038 lw, with mem_ready held low 3 cycles in MEMRD -> 0,1,2,3,3,3,3,4,0; iord=1 throughout MEMRD; memtoreg=1 in MEMWB.
REQ-039 beq with zero=1 -> pc_en=1 and pcsrc=01 in BRANCH; repeat with zero=0 -> pc_en=0.
REQ-040 opcode 111111 -> illegal pulse in DECODE, then FETCH. funct 000000 -> illegal pulse in EXEC, reg_write never asserted.
REQ-041 TIMEOUT=4, mem_ready=0 in FETCH -> mem_err on the 4th FETCH cycle, then FETCH, no ir_write. Repeat with mem_ready=1 on the 4th cycle -> DECODE, no mem_err.
REQ-042 rst_n pulsed low during MEMWR -> outputs 0 asynchronously, mem_write never completes, state=FETCH.
